// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg
// Shared definitions for the ADC capture-to-PS return path:
//   - adc_cap_state_e : capture FSM state encoding (ST_ARMED only exists when
//                       ADC_CAP_TRIG_EN is defined)
//   - HDR_MAGIC and header field positions for the burst header word
//   - lanes()         : number of PS beats per ADC word
//   - make_header()   : assembles the 32-bit header word
package adc_cap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_HEADER  = 3'd2,
`ifdef ADC_CAP_TRIG_EN
        ST_DRAIN   = 3'd3,
        ST_ARMED   = 3'd4
`else
        ST_DRAIN   = 3'd3
`endif
    } adc_cap_state_e;

    localparam logic [15:0] HDR_MAGIC = 16'hADC0;

    // Header word layout: {magic[15:0], chan[3:0], len[11:0]}
    localparam int HDR_WIDTH     = 32;
    localparam int HDR_MAGIC_LSB = 16;
    localparam int HDR_CHAN_LSB  = 12;
    localparam int HDR_LEN_LSB   = 0;

    function automatic int lanes(input int adc_width, input int ps_width);
        return adc_width / ps_width;
    endfunction

    function automatic logic [HDR_WIDTH-1:0] make_header(input logic [3:0]  chan,
                                                         input logic [11:0] len);
        logic [HDR_WIDTH-1:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 16] = HDR_MAGIC;
        h[HDR_CHAN_LSB  +: 4]  = chan;
        h[HDR_LEN_LSB   +: 12] = len;
        return h;
    endfunction

endpackage

// File: rtl/adc_cap_buf.sv
// adc_cap_buf
// Simple dual-port burst buffer, DEPTH x WIDTH, no reset on storage so it maps
// onto block RAM. One write port, one synchronous read port (one-cycle
// latency; rd_data_o holds its value while rd_en_i is low).
// Ports:
//   clk_i      clock
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_en_i    read strobe
//   rd_addr_i  read address
//   rd_data_o  registered read data
module adc_cap_buf #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 128,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/adc_capture_to_ps.sv
// adc_capture_to_ps
// Captures a burst of capture_len ADC words into a local buffer, then sends a
// header word followed by the burst as PS_WIDTH beats (least-significant lane
// first) on the PS AXIS stream.
// Optional feature macro: ADC_CAP_TRIG_EN adds the trig input and the ARMED
// state (data discarded until the first valid beat with trig=1).
// ADC_WIDTH must be a multiple of PS_WIDTH; DEPTH a power of two <= 4095.
// Ports:
//   clk, rst (async, active-low)
//   arm, capture_len       start pulse and burst length (sampled on arm)
//   busy, done             status; done pulses when the final beat is accepted
//   s_axis_*               ADC input stream (tready only while capturing)
//   m_axis_*               PS output stream
//   state_dbg              current FSM state
//   trig                   (ADC_CAP_TRIG_EN only) capture trigger
//
// Stream handshake: a beat transfers on a rising edge where tvalid and tready
// are both high. Once tvalid is raised it, tdata and tlast stay constant until
// that transfer; tvalid is a register and never looks at tready. s_axis_tready
// is a decode of the state only.
module adc_capture_to_ps
    import adc_cap_pkg::*;
#(
    parameter int          ADC_WIDTH = 128,
    parameter int          PS_WIDTH  = 32,
    parameter int          DEPTH     = 256,
    parameter int unsigned CHAN_ID   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic [11:0]          capture_len,
`ifdef ADC_CAP_TRIG_EN
    input  logic                 trig,
`endif
    output logic                 busy,
    output logic                 done,
    input  logic [ADC_WIDTH-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [PS_WIDTH-1:0]  m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [2:0]           state_dbg
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int LANES = lanes(ADC_WIDTH, PS_WIDTH);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LANE_MAX = LW'(LANES - 1);

    adc_cap_state_e state_q, state_d;

    logic [CW-1:0]        len_q,    len_d;
    logic [CW-1:0]        wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]        rd_cnt_q, rd_cnt_d;   // words requested from the buffer
    logic [CW-1:0]        wd_cnt_q, wd_cnt_d;   // words moved into the output path
    logic [LW-1:0]        lane_q,   lane_d;
    logic                 rvalid_q, rvalid_d;   // rd_data holds an unsent word
    logic [ADC_WIDTH-1:0] word_q,   word_d;
    logic [PS_WIDTH-1:0]  m_tdata_q,  m_tdata_d;
    logic                 m_tvalid_q, m_tvalid_d;
    logic                 m_tlast_q,  m_tlast_d;
    logic                 done_q,     done_d;

    logic                 arm_ok;
    logic                 wr_en;
    logic                 wr_last;
    logic                 hdr_accept;
    logic                 last_accept;
    logic                 out_free;
    logic                 new_word;
    logic                 load_beat;
    logic                 rd_en;
    logic [CW-1:0]        beat_word;
    logic [PS_WIDTH-1:0]  beat_data;
    logic                 beat_last;
    logic [ADC_WIDTH-1:0] rd_data;
    logic [HDR_WIDTH-1:0] hdr_word;

`ifdef ADC_CAP_TRIG_EN
    logic trig_hit;
    assign trig_hit = s_axis_tvalid & trig;
`endif

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign arm_ok = (state_q == ST_IDLE) && arm &&
                    (capture_len != 12'd0) && (capture_len <= 12'(DEPTH));

`ifdef ADC_CAP_TRIG_EN
    assign wr_en = ((state_q == ST_CAPTURE) && s_axis_tvalid) ||
                   ((state_q == ST_ARMED) && trig_hit);
`else
    assign wr_en = (state_q == ST_CAPTURE) && s_axis_tvalid;
`endif

    // In ARMED wr_cnt_q is 0, so this also covers len == 1 straight to HEADER.
    assign wr_last     = (wr_cnt_q + CW'(1)) == len_q;
    assign hdr_accept  = (state_q == ST_HEADER) && m_tvalid_q && m_axis_tready;
    assign last_accept = (state_q == ST_DRAIN) && m_tvalid_q && m_axis_tready && m_tlast_q;
    assign out_free    = !m_tvalid_q || m_axis_tready;

    // Lane 0 of each word comes straight from the buffer read port; the word
    // is copied to word_q so the remaining lanes can be sent while the next
    // word is already being fetched.
    assign new_word  = (lane_q == '0);
    assign load_beat = (state_q == ST_DRAIN) && out_free && (!new_word || rvalid_q);
    assign beat_word = new_word ? wd_cnt_q : (wd_cnt_q - CW'(1));
    assign beat_data = new_word ? rd_data[PS_WIDTH-1:0]
                                : word_q[int'(lane_q) * PS_WIDTH +: PS_WIDTH];
    assign beat_last = (lane_q == LANE_MAX) && (beat_word == (len_q - CW'(1)));

    // Reads start in HEADER so word 0 is waiting when the header is accepted.
    assign rd_en = ((state_q == ST_HEADER) || (state_q == ST_DRAIN)) &&
                   (rd_cnt_q != len_q) &&
                   (!rvalid_q || (load_beat && new_word));

    assign hdr_word = make_header(4'(CHAN_ID), 12'(len_q));

    // ------------------------------------------------------------------
    // Burst buffer
    // ------------------------------------------------------------------
    adc_cap_buf #(
        .DEPTH (DEPTH),
        .WIDTH (ADC_WIDTH)
    ) u_buf (
        .clk_i     (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_cnt_q[AW-1:0]),
        .wr_data_i (s_axis_tdata),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_cnt_q[AW-1:0]),
        .rd_data_o (rd_data)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arm_ok) begin
`ifdef ADC_CAP_TRIG_EN
                    state_d = ST_ARMED;
`else
                    state_d = ST_CAPTURE;
`endif
                end
            end
`ifdef ADC_CAP_TRIG_EN
            ST_ARMED: begin
                if (wr_en) begin
                    state_d = wr_last ? ST_HEADER : ST_CAPTURE;
                end
            end
`endif
            ST_CAPTURE: begin
                if (wr_en && wr_last) begin
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (hdr_accept) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q != ST_IDLE);
`ifdef ADC_CAP_TRIG_EN
        s_axis_tready = (state_q == ST_CAPTURE) || (state_q == ST_ARMED);
`else
        s_axis_tready = (state_q == ST_CAPTURE);
`endif
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        len_d      = len_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        wd_cnt_d   = wd_cnt_q;
        lane_d     = lane_q;
        rvalid_d   = rvalid_q;
        word_d     = word_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        done_d     = 1'b0;

        if (arm_ok) begin
            len_d    = capture_len[CW-1:0];
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            wd_cnt_d = '0;
            lane_d   = '0;
            rvalid_d = 1'b0;
        end

        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + CW'(1);
            if (wr_last) begin
                m_tvalid_d = 1'b1;
                m_tdata_d  = PS_WIDTH'(hdr_word);
                m_tlast_d  = 1'b0;
            end
        end

        if (hdr_accept) begin
            m_tvalid_d = 1'b0;
        end

        if ((state_q == ST_DRAIN) && m_tvalid_q && m_axis_tready) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
        end

        if (load_beat) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = beat_data;
            m_tlast_d  = beat_last;
            lane_d     = (lane_q == LANE_MAX) ? '0 : (lane_q + LW'(1));
            if (new_word) begin
                word_d   = rd_data;
                wd_cnt_d = wd_cnt_q + CW'(1);
                rvalid_d = 1'b0;
            end
        end

        if (rd_en) begin
            rd_cnt_d = rd_cnt_q + CW'(1);
            rvalid_d = 1'b1;
        end

        if (last_accept) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q      <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            wd_cnt_q   <= '0;
            lane_q     <= '0;
            rvalid_q   <= 1'b0;
            word_q     <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            len_q      <= len_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            lane_q     <= lane_d;
            rvalid_q   <= rvalid_d;
            word_q     <= word_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            done_q     <= done_d;
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign done          = done_q;
    assign state_dbg     = state_q;

endmodule
